// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - Access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word).
//   - Arbiter state enum.
//   - Lane helpers: load extract/extend, store lane merge and alignment test.
// Lanes are little-endian: lane 0 is bits [7:0] of the memory word.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, MERGE} state_t;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  // A halfword only looks at lane[1] and a word ignores the lane, which is
  // what makes misaligned accesses behave as aligned-down ones.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (lane[1]) r[31:16] = wdata[15:0];
      else         r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  // Halfword on an odd address, or word (including size 2'b11) off a word boundary.
  function automatic logic is_misaligned(input logic [1:0] lane,
                                         input logic [1:0] size);
    return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's connection to the data-memory arbiter.
//   master modport (requester): drives req, we, addr, size, is_unsigned, wdata;
//                               receives gnt, ack, rdata, err.
//   slave modport (arbiter):    the mirror image.
// Request fields must stay stable from req rising until gnt is seen.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] wdata;
  logic        gnt;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, size, is_unsigned, wdata,
                  input  gnt, ack, rdata, err);
  modport slave  (input  req, we, addr, size, is_unsigned, wdata,
                  output gnt, ack, rdata, err);
endinterface

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: purely combinational lane logic shared by loads and the
// read-modify-write store path.
//   word        in  32  memory word (live read data or latched RMW word)
//   wdata       in  32  right-justified store data
//   lane        in  2   byte address bits [1:0]
//   size        in  2   access size encoding
//   is_unsigned in  1   zero-extend loads when 1
//   load_data   out 32  extracted and extended load value
//   merged      out 32  word with the addressed lane(s) replaced by wdata
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  assign load_data = lane_extract(word, lane, size, is_unsigned);
  assign merged    = lane_merge(word, wdata, lane, size);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, word-organised data memory between the
// core load/store unit (m0) and the debug/DMA master (m1).
//   clk, rst             clock and asynchronous active-high reset
//   m0, m1               requester buses (dmem_arbiter_if.slave)
//   mem_addr  out 32     word index {2'b00, addr[31:2]}
//   mem_wdata out 32     word written to memory
//   mem_write out 1      memory write enable
//   mem_read  out 1      memory read enable
//   mem_rdata in  32     combinational memory read data
// Round-robin between the two requesters; loads and word stores complete in
// one cycle (ack on the next), byte/half stores take a read then a merged write.
// Optional build macro: DMEM_MISALIGN_CHECK_EN -- misaligned requests are
// granted but answered with ack+err and never touch memory. Without it the
// low address bits are ignored and mN_err stays 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int RR_RESET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        m0,
  dmem_arbiter_if.slave        m1,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [31:0]          mem_rdata
);

  state_t      state, state_nxt;
  logic        rr_last, rr_nxt;
  logic [1:0]  ack_q, ack_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        err_q, err_nxt;
  // Context held across the RMW read and merge-write cycles.
  logic        owner_q, owner_nxt;
  logic [31:0] word_q, word_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [1:0]  size_q, size_nxt;
  logic [15:0] wdata_q, wdata_nxt;

  logic        gnt0, gnt1, any_gnt, sel;
  logic        sel_we, sel_uns, misaligned;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic [31:0] lane_word, lane_wdata, load_data, merged;
  logic [1:0]  lane_sel, lane_size;

  // Grants only in IDLE and never while reset is held; on contention the
  // requester that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      gnt0 = m0.req && (!m1.req || rr_last);
      gnt1 = m1.req && (!m0.req || !rr_last);
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel       = gnt1;
  assign sel_we    = sel ? m1.we          : m0.we;
  assign sel_addr  = sel ? m1.addr        : m0.addr;
  assign sel_size  = sel ? m1.size        : m0.size;
  assign sel_uns   = sel ? m1.is_unsigned : m0.is_unsigned;
  assign sel_wdata = sel ? m1.wdata       : m0.wdata;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(sel_addr[1:0], sel_size);
`else
  assign misaligned = 1'b0;
`endif

  // In MERGE the lane unit works on the latched word; otherwise on live read data.
  assign lane_word  = (state == MERGE) ? word_q            : mem_rdata;
  assign lane_wdata = (state == MERGE) ? {16'd0, wdata_q}  : sel_wdata;
  assign lane_sel   = (state == MERGE) ? addr_q[1:0]       : sel_addr[1:0];
  assign lane_size  = (state == MERGE) ? size_q            : sel_size;

  dmem_lane_unit u_lane (
    .word        (lane_word),
    .wdata       (lane_wdata),
    .lane        (lane_sel),
    .size        (lane_size),
    .is_unsigned (sel_uns),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Next-state and memory-side outputs.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    ack_nxt   = 2'b00;
    rdata_nxt = '0;
    err_nxt   = 1'b0;
    owner_nxt = owner_q;
    word_nxt  = word_q;
    addr_nxt  = addr_q;
    size_nxt  = size_q;
    wdata_nxt = wdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          rr_nxt = sel;
          if (misaligned) begin
            ack_nxt[sel] = 1'b1;
            err_nxt      = 1'b1;
          end else if (!sel_we) begin
            mem_read     = 1'b1;
            mem_addr     = {2'b00, sel_addr[31:2]};
            ack_nxt[sel] = 1'b1;
            rdata_nxt    = load_data;
          end else if (sel_size[1]) begin
            mem_write    = 1'b1;
            mem_addr     = {2'b00, sel_addr[31:2]};
            mem_wdata    = sel_wdata;
            ack_nxt[sel] = 1'b1;
          end else begin
            // Sub-word store: fetch the old word now, write the merge next cycle.
            mem_read  = 1'b1;
            mem_addr  = {2'b00, sel_addr[31:2]};
            word_nxt  = mem_rdata;
            addr_nxt  = sel_addr;
            size_nxt  = sel_size;
            wdata_nxt = sel_wdata[15:0];
            owner_nxt = sel;
            state_nxt = MERGE;
          end
        end
      end
      MERGE: begin
        mem_write        = 1'b1;
        mem_addr         = {2'b00, addr_q[31:2]};
        mem_wdata        = merged;
        ack_nxt[owner_q] = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts a pending merge and drops any pending ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= (RR_RESET == 0);
      ack_q   <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_nxt;
      ack_q   <= ack_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      owner_q <= owner_nxt;
      word_q  <= word_nxt;
      addr_q  <= addr_nxt;
      size_q  <= size_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign m0.gnt   = gnt0;
  assign m1.gnt   = gnt1;
  assign m0.ack   = ack_q[0];
  assign m1.ack   = ack_q[1];
  assign m0.rdata = ack_q[0] ? rdata_q : '0;
  assign m1.rdata = ack_q[1] ? rdata_q : '0;
  assign m0.err   = ack_q[0] & err_q;
  assign m1.err   = ack_q[1] & err_q;

  a_nreq:     assert property (@(posedge clk) disable iff (rst) NREQ == 2);
  a_rw_excl:  assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
  a_one_gnt:  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Holds a small word memory model, drives both requester interfaces and keeps
// a scoreboard of expected completions (owner, load data, err) that is popped
// as acks appear. Honours DMEM_MISALIGN_CHECK_EN for the misaligned scenario.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] maddr;
    logic [31:0] val;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if m0 ();
  dmem_arbiter_if m1 ();

  dmem_arbiter #(.NREQ(2), .RR_RESET(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0),
    .m1        (m1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  // Memory model: combinational read, write on the rising edge, bench preload port.
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[5:0]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    if (p == 0) begin
      m0.req = 1'b1; m0.we = we; m0.addr = addr; m0.size = size; m0.is_unsigned = uns; m0.wdata = wdata;
    end else begin
      m1.req = 1'b1; m1.we = we; m1.addr = addr; m1.size = size; m1.is_unsigned = uns; m1.wdata = wdata;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) m0.req = 1'b0;
    else        m1.req = 1'b0;
  endtask

  function automatic logic [1:0] gnts();
    return {m1.gnt, m0.gnt};
  endfunction

  function automatic logic [1:0] acks();
    return {m1.ack, m0.ack};
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? m0.rdata : m1.rdata;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 0) ? m0.err : m1.err;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (gnts() !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", gnts()); else passed++;
    checks++; if (acks() !== 2'b00) $display("[TB] FAIL reset_ack: got %b expected 00", acks()); else passed++;
    checks++; if ({mem_read, mem_write} !== 2'b00) $display("[TB] FAIL reset_rw: got %b expected 00", {mem_read, mem_write}); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("[TB] FAIL reset_maddr: got %h expected 0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'h0) $display("[TB] FAIL reset_mwdata: got %h expected 0", mem_wdata); else passed++;
    checks++; if ({m0.rdata, m1.rdata} !== 64'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", {m0.rdata, m1.rdata}); else passed++;
    checks++; if ({m0.err, m1.err} !== 2'b00) $display("[TB] FAIL reset_err: got %b expected 00", {m0.err, m1.err}); else passed++;
    @(posedge clk);
    #1 drop_req(0);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    ld_t  tbl[$];
    exp_t e;
    preload(6'h10, 32'h8899AABB);
    preload(6'h3F, 32'h01234567);
    tbl.push_back('{0, 32'h40, SZ_WORD, 1'b0, 32'h10, 32'h8899AABB});
    tbl.push_back('{0, 32'h43, SZ_BYTE, 1'b0, 32'h10, 32'hFFFFFF88});
    tbl.push_back('{0, 32'h43, SZ_BYTE, 1'b1, 32'h10, 32'h00000088});
    tbl.push_back('{1, 32'h40, SZ_HALF, 1'b1, 32'h10, 32'h0000AABB});
    tbl.push_back('{1, 32'h42, SZ_HALF, 1'b0, 32'h10, 32'hFFFF8899});
    tbl.push_back('{0, 32'h40, SZ_BYTE, 1'b0, 32'h10, 32'hFFFFFFBB});
    tbl.push_back('{1, 32'h41, SZ_BYTE, 1'b1, 32'h10, 32'h000000AA});
    tbl.push_back('{0, 32'h40, SZ_HALF, 1'b0, 32'h10, 32'hFFFFAABB});
    tbl.push_back('{1, 32'h40, 2'b11,   1'b0, 32'h10, 32'h8899AABB});
    tbl.push_back('{0, 32'hFFFFFFFC, SZ_WORD, 1'b0, 32'h3FFFFFFF, 32'h01234567});
    foreach (tbl[i]) begin
      set_req(tbl[i].port, 1'b0, tbl[i].addr, tbl[i].size, tbl[i].uns, 32'h0);
      @(negedge clk);
      checks++; if (gnts() !== onehot(tbl[i].port)) $display("[TB] FAIL load%0d_gnt: got %b expected %b", i, gnts(), onehot(tbl[i].port)); else passed++;
      checks++; if ({mem_read, mem_write} !== 2'b10) $display("[TB] FAIL load%0d_rw: got %b expected 10", i, {mem_read, mem_write}); else passed++;
      checks++; if (mem_addr !== tbl[i].maddr) $display("[TB] FAIL load%0d_maddr: got %h expected %h", i, mem_addr, tbl[i].maddr); else passed++;
      sb.push_back('{tbl[i].port, tbl[i].val, 1'b0});
      @(posedge clk);
      #1 drop_req(tbl[i].port);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL load%0d_ack: got %b expected %b", i, acks(), onehot(e.port)); else passed++;
      checks++; if (rdata_of(e.port) !== e.rdata) $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, rdata_of(e.port), e.rdata); else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_byte_store_rmw();
    exp_t e;
    preload(6'h10, 32'h11223344);
    preload(6'h11, 32'hCAFEF00D);
    set_req(0, 1'b1, 32'h41, SZ_BYTE, 1'b0, 32'hABCDEFEE);
    @(negedge clk);
    checks++; if (gnts() !== 2'b01) $display("[TB] FAIL sb_gnt: got %b expected 01", gnts()); else passed++;
    checks++; if ({mem_read, mem_write} !== 2'b10) $display("[TB] FAIL sb_read: got %b expected 10", {mem_read, mem_write}); else passed++;
    checks++; if (mem_addr !== 32'h10) $display("[TB] FAIL sb_raddr: got %h expected 10", mem_addr); else passed++;
    sb.push_back('{0, 32'h0, 1'b0});
    @(posedge clk);
    #1 drop_req(0);
    set_req(1, 1'b0, 32'h44, SZ_WORD, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (gnts() !== 2'b00) $display("[TB] FAIL sb_merge_gnt: got %b expected 00", gnts()); else passed++;
    checks++; if ({mem_read, mem_write} !== 2'b01) $display("[TB] FAIL sb_write: got %b expected 01", {mem_read, mem_write}); else passed++;
    checks++; if (mem_wdata !== 32'h1122EE44) $display("[TB] FAIL sb_wdata: got %h expected 1122ee44", mem_wdata); else passed++;
    checks++; if (acks() !== 2'b00) $display("[TB] FAIL sb_early_ack: got %b expected 00", acks()); else passed++;
    @(posedge clk);
    #1;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL sb_ack: got %b expected %b", acks(), onehot(e.port)); else passed++;
    checks++; if (gnts() !== 2'b10) $display("[TB] FAIL sb_next_gnt: got %b expected 10", gnts()); else passed++;
    sb.push_back('{1, 32'hCAFEF00D, 1'b0});
    @(posedge clk);
    #1 drop_req(1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL sb_m1_ack: got %b expected %b", acks(), onehot(e.port)); else passed++;
    checks++; if (rdata_of(e.port) !== e.rdata) $display("[TB] FAIL sb_m1_rdata: got %h expected %h", rdata_of(e.port), e.rdata); else passed++;
    checks++; if (mem[16] !== 32'h1122EE44) $display("[TB] FAIL sb_mem: got %h expected 1122ee44", mem[16]); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          w;
    int          prev;
    logic [31:0] exp_wd;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    prev = 0;
    set_req(0, 1'b1, 32'h80, SZ_WORD, 1'b0, 32'hA0000000);
    set_req(1, 1'b1, 32'h84, SZ_WORD, 1'b0, 32'hB0000001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      w = k % 2;
      exp_wd = ((w == 0) ? 32'hA0000000 : 32'hB0000000) + 32'(k);
      checks++; if (gnts() !== onehot(w)) $display("[TB] FAIL rr%0d_gnt: got %b expected %b", k, gnts(), onehot(w)); else passed++;
      checks++; if (mem_wdata !== exp_wd) $display("[TB] FAIL rr%0d_wdata: got %h expected %h", k, mem_wdata, exp_wd); else passed++;
      if (k > 0) begin
        e = sb.pop_front();
        checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL rr%0d_ack: got %b expected %b", k, acks(), onehot(e.port)); else passed++;
      end
      sb.push_back('{w, 32'h0, 1'b0});
      prev = w;
      @(posedge clk);
      #1;
      if (w == 0) set_req(0, 1'b1, 32'h80, SZ_WORD, 1'b0, 32'hA0000000 + 32'(k + 2));
      else        set_req(1, 1'b1, 32'h84, SZ_WORD, 1'b0, 32'hB0000000 + 32'(k + 2));
    end
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL rr_last_ack: got %b expected %b (last %0d)", acks(), onehot(e.port), prev); else passed++;
    checks++; if (mem[32] !== 32'hA0000004) $display("[TB] FAIL rr_mem0: got %h expected a0000004", mem[32]); else passed++;
    checks++; if (mem[33] !== 32'hB0000005) $display("[TB] FAIL rr_mem1: got %h expected b0000005", mem[33]); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_merge();
    exp_t e;
    preload(6'h10, 32'h11223344);
    set_req(0, 1'b1, 32'h42, SZ_HALF, 1'b0, 32'h0000BEEF);
    @(negedge clk);
    checks++; if ({gnts(), mem_read} !== 3'b011) $display("[TB] FAIL rm_gnt_read: got %b expected 011", {gnts(), mem_read}); else passed++;
    @(posedge clk);
    #1 drop_req(0);
    checks++; if (mem_write !== 1'b1) $display("[TB] FAIL rm_merge_write: got %b expected 1", mem_write); else passed++;
    checks++; if (mem_wdata !== 32'hBEEF3344) $display("[TB] FAIL rm_merge_wdata: got %h expected beef3344", mem_wdata); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) $display("[TB] FAIL rm_write_drop: got %b expected 0", mem_write); else passed++;
    @(negedge clk);
    checks++; if (acks() !== 2'b00) $display("[TB] FAIL rm_ack_rst: got %b expected 00", acks()); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (acks() !== 2'b00) $display("[TB] FAIL rm_ack_after: got %b expected 00", acks()); else passed++;
    checks++; if (mem[16] !== 32'h11223344) $display("[TB] FAIL rm_mem: got %h expected 11223344", mem[16]); else passed++;
    set_req(1, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);
    #1;
    checks++; if (gnts() !== 2'b10) $display("[TB] FAIL rm_idle_gnt: got %b expected 10", gnts()); else passed++;
    sb.push_back('{1, 32'h11223344, 1'b0});
    @(posedge clk);
    #1 drop_req(1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rdata_of(e.port) !== e.rdata) $display("[TB] FAIL rm_reload: got %h expected %h", rdata_of(e.port), e.rdata); else passed++;
    // A halfword store that is allowed to finish.
    @(posedge clk);
    #1 set_req(0, 1'b1, 32'h42, SZ_HALF, 1'b0, 32'h0000BEEF);
    sb.push_back('{0, 32'h0, 1'b0});
    @(posedge clk);
    #1 drop_req(0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL sh_ack: got %b expected %b", acks(), onehot(e.port)); else passed++;
    @(negedge clk);
    checks++; if (mem[16] !== 32'hBEEF3344) $display("[TB] FAIL sh_mem: got %h expected beef3344", mem[16]); else passed++;
  endtask

  task automatic test_misalign();
    exp_t e;
    preload(6'h10, 32'h8899AABB);
    set_req(0, 1'b0, 32'h41, SZ_WORD, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (gnts() !== 2'b01) $display("[TB] FAIL mis_ld_gnt: got %b expected 01", gnts()); else passed++;
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if ({mem_read, mem_write} !== 2'b00) $display("[TB] FAIL mis_ld_rw: got %b expected 00", {mem_read, mem_write}); else passed++;
    sb.push_back('{0, 32'h0, 1'b1});
`else
    checks++; if ({mem_read, mem_addr} !== {1'b1, 32'h10}) $display("[TB] FAIL mis_ld_rw: got %b/%h expected 1/10", mem_read, mem_addr); else passed++;
    sb.push_back('{0, 32'h8899AABB, 1'b0});
`endif
    @(posedge clk);
    #1 drop_req(0);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (acks() !== onehot(e.port)) $display("[TB] FAIL mis_ld_ack: got %b expected %b", acks(), onehot(e.port)); else passed++;
    checks++; if (rdata_of(e.port) !== e.rdata) $display("[TB] FAIL mis_ld_rdata: got %h expected %h", rdata_of(e.port), e.rdata); else passed++;
    checks++; if (err_of(e.port) !== e.err) $display("[TB] FAIL mis_ld_err: got %b expected %b", err_of(e.port), e.err); else passed++;
    @(posedge clk);
    #1 set_req(1, 1'b1, 32'h43, SZ_HALF, 1'b0, 32'h00001234);
    @(posedge clk);
    #1 drop_req(1);
`ifdef DMEM_MISALIGN_CHECK_EN
    @(negedge clk);
    checks++; if ({m1.ack, m1.err} !== 2'b11) $display("[TB] FAIL mis_st_ackerr: got %b expected 11", {m1.ack, m1.err}); else passed++;
    checks++; if (mem[16] !== 32'h8899AABB) $display("[TB] FAIL mis_st_mem: got %h expected 8899aabb", mem[16]); else passed++;
`else
    @(negedge clk);
    checks++; if (mem_wdata !== 32'h1234AABB) $display("[TB] FAIL mis_st_wdata: got %h expected 1234aabb", mem_wdata); else passed++;
    @(negedge clk);
    checks++; if ({m1.ack, m1.err} !== 2'b10) $display("[TB] FAIL mis_st_ackerr: got %b expected 10", {m1.ack, m1.err}); else passed++;
    checks++; if (mem[16] !== 32'h1234AABB) $display("[TB] FAIL mis_st_mem: got %h expected 1234aabb", mem[16]); else passed++;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0.req = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.size = SZ_BYTE; m0.is_unsigned = 1'b0; m0.wdata = '0;
    m1.req = 1'b0; m1.we = 1'b0; m1.addr = '0; m1.size = SZ_BYTE; m1.is_unsigned = 1'b0; m1.wdata = '0;
    test_reset();
    test_loads();
    test_byte_store_rmw();
    test_back_to_back();
    test_reset_merge();
    test_misalign();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port, word-organised data memory between two requesters.
  - Port 0: core load/store unit.
  - Port 1: debug/DMA.
- Performs round-robin arbitration, byte/halfword/word access sizing, and load sign/zero extension.
- Implements sub-word stores as a read-modify-write (RMW) sequence, because the memory only writes whole 32-bit words.
- Sits between the pipeline MEM stage (and the debug master) and the data memory.

Parameters:
- NREQ, 2, number of requesters. Fixed at 2; exists for documentation and assertions.
- RR_RESET, 0, requester that holds priority after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mN_req  in  1  request, N in {0,1}. Held with its fields stable until mN_gnt.
- mN_we  in  1  1 = store, 0 = load.
- mN_addr  in  32  byte address.
- mN_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mN_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- mN_wdata  in  32  store data, right-justified.
- mN_gnt  out  1  request accepted this cycle (combinational).
- mN_ack  out  1  one-cycle completion pulse.
- mN_rdata  out  32  extended load data; valid while mN_ack=1 for a load.
- mN_err  out  1  misaligned-access flag, qualified by mN_ack. Only meaningful with the optional feature.
- mem_addr  out  32  word index = {2'b00, addr[31:2]}.
- mem_wdata  out  32  word written to memory.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- States: IDLE, MERGE.
- Reset values:
  - State = IDLE, rr_last = ~RR_RESET.
  - All gnt/ack/err = 0, rdata = 0.
  - mem_read = mem_write = 0; mem_addr and mem_wdata = 0.
- IDLE arbitration:
  - If exactly one requester asserts req, it is granted.
  - If both assert req, the requester not equal to rr_last is granted.
  - rr_last updates to the granted index on the grant edge.
  - No grant is issued in MERGE.
- Load, granted at cycle T:
  - mem_read=1 at T; mem_rdata is captured at the T edge.
  - Lane selected by addr[1:0] (little-endian), then extended per size/unsigned.
  - ack=1 and rdata valid at T+1.
- Word store, granted at T:
  - mem_write=1 with mem_wdata=wdata at T.
  - ack at T+1.
- Byte/half store, granted at T:
  - mem_read=1 at T; the word is latched.
  - Go to MERGE. At T+1, mem_write=1 with mem_wdata = latched word with lane(s) at addr[1:0] replaced by wdata[7:0] or wdata[15:0].
  - ack at T+2. Return to IDLE at T+2, where a new grant is possible.
- mem_read and mem_write are never both 1 in the same cycle.
- ack pulses go only to the requester that was granted.
- A requester dropping req without gnt is legal; nothing is recorded.
- rst during MERGE:
  - The merge write is suppressed: mem_write falls immediately.
  - No ack is issued.
  - The memory keeps its old word.
- Halfword at addr[0]=1, or word at addr[1:0]!=0, without the feature: low address bits are ignored, i.e. the access is treated as aligned down.
- Address wrap: mem_addr uses addr[31:2] only; no carry is ever generated.

Optional Feature:
- DMEM_MISALIGN_CHECK_EN
- Defined:
  - A misaligned request is granted but issues no mem_read or mem_write.
  - At T+1 the requester gets ack=1, err=1, rdata=0.
  - Memory is unchanged; rr_last still updates.
- Undefined:
  - mN_err is tied 0.
  - Misaligned requests are aligned down as above.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State enum {IDLE, MERGE}.
  - Functions for lane extract/extend and lane merge.
- One natural sub-module, dmem_lane_unit: purely combinational. It contains the extract/sign-extend and merge logic, shared by the load and RMW paths.

Test Plan:
- Word load: mem[0x10]=0x8899AABB; m0 loads word at addr 0x40 -> gnt at T, mem_read=1, mem_addr=0x10; ack and rdata=0x8899AABB at T+1.
- Byte load: same word; lb at 0x43 -> rdata=0xFFFFFF88. lbu at 0x43 -> 0x00000088. lhu at 0x40 -> 0x0000AABB.
- Byte store RMW: mem[0x10]=0x11223344; sb 0xEE at 0x41 -> read at T, write 0x1122EE44 at T+1, ack at T+2, no gnt at T+1.
- Contention: m0 and m1 both req continuously with word stores -> grants alternate m0,m1,m0,... starting with m0 after reset; each ack goes only to its owner.
- Reset during MERGE: sh 0xBEEF at 0x42 with rst asserted at T+1 -> mem_write stays 0, no ack, word unchanged, state IDLE.
- With DMEM_MISALIGN_CHECK_EN, lw at 0x41 -> no mem_read/mem_write; ack=1, err=1, rdata=0 at T+1. Without it -> reads word 0x10, err=0.
